// File: rtl/video_pkg.sv
// Shared definitions for the video host front end: host register map,
// CTRL/STATUS bit positions and the VRAM drain FSM encoding.
package video_pkg;

    localparam logic [1:0] REG_ADL  = 2'd0;
    localparam logic [1:0] REG_ADH  = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_OVF    = 7;

    localparam int STAT_IRQ   = 7;
    localparam int STAT_BUSY  = 6;
    localparam int STAT_FULL  = 5;
    localparam int STAT_EMPTY = 4;

    typedef enum logic [1:0] {
        DR_IDLE   = 2'd0,
        DR_SETUP  = 2'd1,
        DR_STROBE = 2'd2,
        DR_HOLD   = 2'd3
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock)
        mem_q <= mem_d;

endmodule

// File: rtl/vram_host_write_queue.sv
// Host register window into VRAM: synchronises host strobes, queues DATA writes
// with auto-increment, and drains the queue as 3-cycle VRAM writes during blanking.
module vram_host_write_queue
    import video_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hcs_n,
    input  logic        hwr_n,
    input  logic        hrd_n,
    input  logic [1:0]  ha,
    input  logic [7:0]  hd_in,
    output logic [7:0]  hd_out,
    output logic        hd_oe,
    output logic        hwait_n,
    output logic        hint_n,
    input  logic        vram_free,
    input  logic        vblank_start,
    output logic        vram_busy,
    output logic [15:0] va_out,
    output logic [7:0]  vd_out,
    output logic        vd_oe,
    output logic        vwe_n
);
    logic [SYNC_STAGES-1:0]       cs_sync_q, cs_sync_d, wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0][1:0]  ha_sync_q, ha_sync_d;
    logic                         wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
    logic                         cs_s, wr_s, rd_s, wr_evt, rd_evt;
    logic [1:0]                   ha_s;

    logic [7:0]   adl_q, adl_d, adh_q, adh_d;
    logic         irq_en_q, irq_en_d, ovf_q, ovf_d, irq_pend_q, irq_pend_d;
    drain_state_t state_q, state_d;
    logic [15:0]  va_q, va_d;
    logic [7:0]   vd_q, vd_d;

    logic                   push, pop, flush, fifo_full, fifo_empty;
    logic [23:0]            fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [31:0]            level_ext;
    logic [7:0]             status;

    always_comb begin
        cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], hcs_n};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], hwr_n};
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], hrd_n};
        ha_sync_d = {ha_sync_q[SYNC_STAGES-2:0], ha};
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign wr_s      = wr_sync_q[SYNC_STAGES-1];
    assign rd_s      = rd_sync_q[SYNC_STAGES-1];
    assign ha_s      = ha_sync_q[SYNC_STAGES-1];
    assign wr_prev_d = wr_s;
    assign rd_prev_d = rd_s;
    assign wr_evt    = ~cs_s & wr_s & ~wr_prev_q;
    assign rd_evt    = ~cs_s & rd_s & ~rd_prev_q;

    assign hd_oe   = ~hcs_n & ~hrd_n;
    assign hwait_n = ~(~cs_s & (ha_s == REG_DATA) & ~wr_s & fifo_full);
    assign hint_n  = ~irq_pend_q;

    assign level_ext = 32'(fifo_level);
    assign status = {irq_pend_q, vram_busy, fifo_full, fifo_empty, 1'b0,
                     (level_ext > 32'd7) ? 3'd7 : level_ext[2:0]};

    always_comb begin
        hd_out = '0;
        if (~cs_s & ~rd_s) begin
            case (ha_s)
                REG_ADL:  hd_out = adl_q;
                REG_ADH:  hd_out = adh_q;
                REG_CTRL: hd_out = status;
                default:  hd_out = '0;
            endcase
        end
    end

    // Drain FSM: the head entry is popped into the output registers on entry to SETUP.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        va_d    = va_q;
        vd_d    = vd_q;
        case (state_q)
            DR_IDLE, DR_HOLD: begin
                state_d = DR_IDLE;
                if (!fifo_empty && vram_free) begin
                    state_d      = DR_SETUP;
                    pop          = 1'b1;
                    {va_d, vd_d} = fifo_rdata;
                end
            end
            DR_SETUP:  state_d = DR_STROBE;
            DR_STROBE: state_d = DR_HOLD;
            default:   state_d = DR_IDLE;
        endcase
    end

    assign vram_busy = (state_q != DR_IDLE);
    assign vd_oe     = vram_busy;
    assign vwe_n     = (state_q != DR_STROBE);
    assign va_out    = va_q;
    assign vd_out    = vd_q;

    always_comb begin
        adl_d      = adl_q;
        adh_d      = adh_q;
        irq_en_d   = irq_en_q;
        ovf_d      = ovf_q;
        irq_pend_d = irq_pend_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (rd_evt && ha_s == REG_CTRL)
            irq_pend_d = 1'b0;
        if (vblank_start && irq_en_q)
            irq_pend_d = 1'b1;
        if (wr_evt) begin
            case (ha_s)
                REG_ADL: adl_d = hd_in;
                REG_ADH: adh_d = hd_in;
                REG_DATA: begin
                    if (!fifo_full || pop) begin
                        push           = 1'b1;
                        {adh_d, adl_d} = {adh_q, adl_q} + 16'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    irq_en_d = hd_in[CTRL_IRQ_EN];
                    flush    = hd_in[CTRL_FLUSH];
                    if (!hd_in[CTRL_IRQ_EN])
                        irq_pend_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync_q  <= '1;
            wr_sync_q  <= '1;
            rd_sync_q  <= '1;
            ha_sync_q  <= '0;
            wr_prev_q  <= 1'b1;
            rd_prev_q  <= 1'b1;
            adl_q      <= '0;
            adh_q      <= '0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            state_q    <= DR_IDLE;
            va_q       <= '0;
            vd_q       <= '0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            wr_sync_q  <= wr_sync_d;
            rd_sync_q  <= rd_sync_d;
            ha_sync_q  <= ha_sync_d;
            wr_prev_q  <= wr_prev_d;
            rd_prev_q  <= rd_prev_d;
            adl_q      <= adl_d;
            adh_q      <= adh_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            irq_pend_q <= irq_pend_d;
            state_q    <= state_d;
            va_q       <= va_d;
            vd_q       <= vd_d;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({adh_q, adl_q, hd_in}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_vram_host_write_queue.sv
// Directed bench for the host write queue: register access, VRAM drain timing,
// overflow, interrupt, flush and reset-during-write.
module tb_vram_host_write_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hcs_n = 1'b1, hwr_n = 1'b1, hrd_n = 1'b1;
    logic [1:0]  ha = 2'd0;
    logic [7:0]  hd_in = 8'd0;
    logic [7:0]  hd_out;
    logic        hd_oe, hwait_n, hint_n;
    logic        vram_free = 1'b0, vblank_start = 1'b0;
    logic        vram_busy, vd_oe, vwe_n;
    logic [15:0] va_out;
    logic [7:0]  vd_out;

    int checks = 0;
    int errors = 0;

    // VRAM write log, appended on every cycle vwe_n is low
    int          cyc = 0;
    int          n_log = 0;
    logic [15:0] log_a [0:63];
    logic [7:0]  log_d [0:63];
    int          log_c [0:63];

    vram_host_write_queue #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .hcs_n(hcs_n), .hwr_n(hwr_n), .hrd_n(hrd_n),
        .ha(ha), .hd_in(hd_in), .hd_out(hd_out), .hd_oe(hd_oe), .hwait_n(hwait_n),
        .hint_n(hint_n), .vram_free(vram_free), .vblank_start(vblank_start),
        .vram_busy(vram_busy), .va_out(va_out), .vd_out(vd_out), .vd_oe(vd_oe), .vwe_n(vwe_n)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!vwe_n && n_log < 64) begin
            log_a[n_log] = va_out;
            log_d[n_log] = vd_out;
            log_c[n_log] = cyc;
            n_log = n_log + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        ha = a; hd_in = d; hcs_n = 1'b0; hwr_n = 1'b0;
        clk(4);
        hwr_n = 1'b1;
        clk(4);
        hcs_n = 1'b1;
        clk(2);
    endtask

    task automatic host_read(input logic [1:0] a, output logic [7:0] d);
        ha = a; hcs_n = 1'b0; hrd_n = 1'b0;
        clk(4);
        d = hd_out;
        checks++;
        assert (hd_oe === 1'b1) else begin
            errors++;
            $error("FAIL hd_oe: observed %b expected 1", hd_oe);
        end
        hrd_n = 1'b1;
        clk(4);
        hcs_n = 1'b1;
        clk(2);
    endtask

    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            clk(1);
            if (vwe_n === 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        bit         seen;
        int         base;

        clk(3);
        check("rst_hd_out", hd_out, 8'h00);
        check("rst_hwait_n", hwait_n, 1'b1);
        check("rst_hint_n", hint_n, 1'b1);
        check("rst_busy", vram_busy, 1'b0);
        check("rst_vd_oe", vd_oe, 1'b0);
        check("rst_vwe_n", vwe_n, 1'b1);
        check("rst_va", va_out, 16'h0000);
        check("rst_vd", vd_out, 8'h00);
        reset = 1'b0;
        clk(2);

        // Auto-increment across a byte boundary, then a back-to-back drain
        host_write(2'd0, 8'hFE);
        host_write(2'd1, 8'h12);
        host_write(2'd2, 8'hAA);
        host_write(2'd2, 8'hBB);
        host_write(2'd2, 8'hCC);
        host_read(2'd3, rd);
        check("t1_status_l3", rd, 8'h03);
        base = n_log;
        vram_free = 1'b1;
        clk(15);
        check("t1_nwrites", n_log - base, 3);
        check("t1_a0", log_a[base], 16'h12FE);
        check("t1_d0", log_d[base], 8'hAA);
        check("t1_a1", log_a[base+1], 16'h12FF);
        check("t1_d1", log_d[base+1], 8'hBB);
        check("t1_a2", log_a[base+2], 16'h1300);
        check("t1_d2", log_d[base+2], 8'hCC);
        check("t1_gap01", log_c[base+1] - log_c[base], 3);
        check("t1_gap12", log_c[base+2] - log_c[base+1], 3);
        check("t1_idle_busy", vram_busy, 1'b0);
        host_read(2'd3, rd);
        check("t1_status_empty", rd, 8'h10);

        // Overflow with the bus blocked, address wrap FFFF->0000
        vram_free = 1'b0;
        host_write(2'd0, 8'hFF);
        host_write(2'd1, 8'hFF);
        host_write(2'd2, 8'h10);
        host_write(2'd2, 8'h11);
        host_write(2'd2, 8'h12);
        host_write(2'd2, 8'h13);
        ha = 2'd2; hd_in = 8'h14; hcs_n = 1'b0; hwr_n = 1'b0;
        clk(4);
        check("t2_hwait_low", hwait_n, 1'b0);
        hwr_n = 1'b1;
        clk(4);
        check("t2_hwait_release", hwait_n, 1'b1);
        hcs_n = 1'b1;
        clk(2);
        check("t2_ovf", dut.ovf_q, 1'b1);
        host_read(2'd3, rd);
        check("t2_status_full", rd, 8'h24);
        host_read(2'd0, rd);
        check("t2_adl_noinc", rd, 8'h03);
        host_read(2'd1, rd);
        check("t2_adh_wrap", rd, 8'h00);
        base = n_log;
        vram_free = 1'b1;
        clk(20);
        check("t2_nwrites", n_log - base, 4);
        check("t2_a0", log_a[base], 16'hFFFF);
        check("t2_d0", log_d[base], 8'h10);
        check("t2_a1", log_a[base+1], 16'h0000);
        check("t2_a2", log_a[base+2], 16'h0001);
        check("t2_a3", log_a[base+3], 16'h0002);
        check("t2_d3", log_d[base+3], 8'h13);

        // Vblank interrupt: set, read-clear, and disable-clear
        check("t3_irq_off", hint_n, 1'b1);
        vblank_start = 1'b1; clk(1); vblank_start = 1'b0; clk(1);
        check("t3_irq_masked", hint_n, 1'b1);
        host_write(2'd3, 8'h01);
        vblank_start = 1'b1; clk(1); vblank_start = 1'b0; clk(1);
        check("t3_hint_low", hint_n, 1'b0);
        host_read(2'd3, rd);
        check("t3_status_irq", rd, 8'h90);
        check("t3_hint_cleared", hint_n, 1'b1);
        vblank_start = 1'b1; clk(1); vblank_start = 1'b0; clk(1);
        check("t3_hint_again", hint_n, 1'b0);
        host_write(2'd3, 8'h00);
        check("t3_hint_disable", hint_n, 1'b1);

        // vram_free drops mid-write: the write still completes
        vram_free = 1'b0;
        host_write(2'd0, 8'h00);
        host_write(2'd1, 8'h20);
        host_write(2'd2, 8'h01);
        host_write(2'd2, 8'h02);
        host_write(2'd2, 8'h03);
        host_write(2'd2, 8'h04);
        base = n_log;
        vram_free = 1'b1;
        wait_strobe(seen);
        check("t4_strobe_seen", seen, 1'b1);
        vram_free = 1'b0;
        clk(1);
        check("t4_hold_busy", vram_busy, 1'b1);
        check("t4_hold_vwe", vwe_n, 1'b1);
        clk(1);
        check("t4_idle", vram_busy, 1'b0);
        clk(8);
        check("t4_nwrites", n_log - base, 1);
        check("t4_a0", log_a[base], 16'h2000);
        host_read(2'd3, rd);
        check("t4_status_l3", rd, 8'h03);

        // Reset while the write strobe is active
        vram_free = 1'b1;
        wait_strobe(seen);
        check("t5_strobe_seen", seen, 1'b1);
        reset = 1'b1;
        clk(1);
        check("t5_vwe_n", vwe_n, 1'b1);
        check("t5_busy", vram_busy, 1'b0);
        check("t5_vd_oe", vd_oe, 1'b0);
        reset = 1'b0;
        clk(2);
        host_read(2'd3, rd);
        check("t5_status_empty", rd, 8'h10);
        host_read(2'd0, rd);
        check("t5_adl", rd, 8'h00);
        host_read(2'd1, rd);
        check("t5_adh", rd, 8'h00);

        // Flush discards queued entries without touching VRAM
        vram_free = 1'b0;
        host_write(2'd2, 8'h31);
        host_write(2'd2, 8'h32);
        host_write(2'd2, 8'h33);
        host_read(2'd3, rd);
        check("t6_status_l3", rd, 8'h03);
        host_write(2'd3, 8'h02);
        host_read(2'd3, rd);
        check("t6_status_flushed", rd, 8'h10);
        base = n_log;
        vram_free = 1'b1;
        clk(10);
        check("t6_no_writes", n_log - base, 0);
        check("t6_busy", vram_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
